dcache_assoc: RTL and testbench

DCACHE_ASSOC -- requirements
Module: dcache_assoc

---
 rtl/dcache_assoc.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dcache_assoc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_assoc.sv
// Set-associative write-back, write-allocate data cache.
// One outstanding CPU request; line refill and write-back over full-line L2 channels.
// A flush walks every line, writes back dirty ones and invalidates the whole cache.
module dcache_assoc #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WORDS = 8,
  parameter int SETS        = 128,
  parameter int WAYS        = 2,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int BYTE_W     = $clog2(STRB_W),
  localparam int OFFSET     = $clog2(BLOCK_WORDS * STRB_W),
  localparam int LINE_W     = BLOCK_WORDS * DATA_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic                     REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0]    REQ_ADDR,
  input  logic [STRB_W-1:0]        REQ_WSTRB,
  input  logic [DATA_WIDTH-1:0]    REQ_WDATA,
  output logic                     RESP_VALID,
  output logic [DATA_WIDTH-1:0]    RESP_DATA,
  output logic                     L2_RADDR_VALID,
  output logic [ADDR_WIDTH-OFFSET-1:0] L2_RADDR,
  input  logic [LINE_W-1:0]        L2_RDATA,
  input  logic                     L2_RDATA_VALID,
  output logic                     L2_WVALID,
  output logic [ADDR_WIDTH-OFFSET-1:0] L2_WADDR,
  output logic [LINE_W-1:0]        L2_WDATA,
  input  logic                     L2_WDONE,
  input  logic                     FLUSH,
  output logic                     FLUSH_DONE
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_WIDTH - INDEX_W - OFFSET;
  localparam int WSEL_W  = OFFSET - BYTE_W;
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, REFILL, RESPOND, FLUSH_WALK} state_t;

  state_t state_q, state_d;

  // Registered request
  logic                  req_write_q;
  logic [STRB_W-1:0]     req_strb_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [TAG_W-1:0]      req_tag_q;
  logic [INDEX_W-1:0]    req_index_q;
  logic [WSEL_W-1:0]     req_wsel_q;
  logic [DATA_WIDTH-1:0] resp_q;
  logic [WAY_W-1:0]      victim_q;
  logic                  victim_valid_q;

  // Line state and replacement
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];

  // Flush walk
  logic [INDEX_W-1:0] flush_set_q;
  logic [WAY_W-1:0]   flush_way_q;
  logic               flush_done_q;

  // Storage and its registered read port
  logic [LINE_W-1:0] data_mem [WAYS][SETS];
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0] rd_line  [WAYS];
  logic [TAG_W-1:0]  rd_tag   [WAYS];

  logic                  accept, hit, flush_dirty, flush_step, flush_last, mem_we;
  logic [WAY_W-1:0]      hit_way, victim_way, mem_way;
  logic [INDEX_W-1:0]    rd_index;
  logic [LINE_W-1:0]     src_line, merged_line;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^REQ_ADDR[BYTE_W-1:0];

  function automatic logic [LINE_W-1:0] merge_line(
    input logic [LINE_W-1:0]     line,
    input logic [WSEL_W-1:0]     sel,
    input logic [STRB_W-1:0]     strb,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic                  wr
  );
    logic [LINE_W-1:0] r;
    r = line;
    if (wr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb[b]) r[int'(sel) * DATA_WIDTH + b * 8 +: 8] = wdata[b * 8 +: 8];
      end
    end
    return r;
  endfunction

  assign accept      = REQ_VALID && REQ_READY;
  assign flush_dirty = valid_q[flush_set_q][flush_way_q] && dirty_q[flush_set_q][flush_way_q];
  assign flush_step  = (state_q == FLUSH_WALK) && (!flush_dirty || L2_WDONE);
  assign flush_last  = (flush_set_q == INDEX_W'(SETS - 1)) && (flush_way_q == WAY_W'(WAYS - 1));

  // Tag compare across all ways plus victim selection (lowest invalid way, else round-robin)
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_way = rr_q[req_index_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_index_q][w] && (rd_tag[w] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_index_q][w]) victim_way = WAY_W'(w);
    end
  end

  // Write merge shared by write hits and refills; read requests pass the line unchanged
  always_comb begin
    src_line    = (state_q == REFILL) ? L2_RDATA : rd_line[hit_way];
    merged_line = merge_line(src_line, req_wsel_q, req_strb_q, req_wdata_q, req_write_q);
    merged_word = merged_line[int'(req_wsel_q) * DATA_WIDTH +: DATA_WIDTH];
    mem_way     = (state_q == REFILL) ? victim_q : hit_way;
    mem_we      = !RST && (((state_q == LOOKUP) && hit && req_write_q) ||
                           ((state_q == REFILL) && L2_RDATA_VALID));
  end

  // Read index tracks whichever set the next state needs to see
  always_comb begin
    rd_index = req_index_q;
    if (state_q == IDLE) begin
      rd_index = FLUSH ? '0 : REQ_ADDR[OFFSET +: INDEX_W];
    end else if (state_q == FLUSH_WALK) begin
      rd_index = (flush_step && (flush_way_q == WAY_W'(WAYS - 1))) ? flush_set_q + 1'b1 : flush_set_q;
    end
  end

  // Data and tag arrays: one write port, one registered read of all ways
  // NOTE: the arrays carry no reset; valid bits alone decide whether their contents mean anything.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      data_mem[mem_way][req_index_q] <= merged_line;
      tag_mem[mem_way][req_index_q]  <= req_tag_q;
    end
    for (int w = 0; w < WAYS; w++) begin
      rd_line[w] <= data_mem[w][rd_index];
      rd_tag[w]  <= tag_mem[w][rd_index];
    end
  end

  // State register
  // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  // NOTE: state_d is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (FLUSH) state_d = FLUSH_WALK;
                  else if (accept) state_d = LOOKUP;
      LOOKUP:     if (hit) state_d = RESPOND;
                  else if (valid_q[req_index_q][victim_way] && dirty_q[req_index_q][victim_way])
                    state_d = EVICT;
                  else state_d = REFILL;
      EVICT:      if (L2_WDONE) state_d = REFILL;
      REFILL:     if (L2_RDATA_VALID) state_d = RESPOND;
      RESPOND:    state_d = IDLE;
      FLUSH_WALK: if (flush_step && flush_last) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Output decode; everything idles at zero
  always_comb begin
    REQ_READY      = (state_q == IDLE) && !FLUSH && !RST;
    RESP_VALID     = 1'b0;
    RESP_DATA      = '0;
    L2_RADDR_VALID = 1'b0;
    L2_RADDR       = '0;
    L2_WVALID      = 1'b0;
    L2_WADDR       = '0;
    L2_WDATA       = '0;
    FLUSH_DONE     = flush_done_q;
    case (state_q)
      RESPOND: begin
        RESP_VALID = 1'b1;
        RESP_DATA  = resp_q;
      end
      REFILL: begin
        L2_RADDR_VALID = 1'b1;
        L2_RADDR       = {req_tag_q, req_index_q};
      end
      EVICT: begin
        L2_WVALID = 1'b1;
        L2_WADDR  = {rd_tag[victim_q], req_index_q};
        L2_WDATA  = rd_line[victim_q];
      end
      FLUSH_WALK: begin
        L2_WVALID = flush_dirty;
        L2_WADDR  = flush_dirty ? {rd_tag[flush_way_q], flush_set_q} : '0;
        L2_WDATA  = flush_dirty ? rd_line[flush_way_q] : '0;
      end
      default: ;
    endcase
  end

  // Request capture, victim choice and response word
  always_ff @(posedge CLK) begin
    if (accept) begin
      req_write_q <= REQ_WRITE;
      req_strb_q  <= REQ_WSTRB;
      req_wdata_q <= REQ_WDATA;
      req_tag_q   <= REQ_ADDR[ADDR_WIDTH-1 -: TAG_W];
      req_index_q <= REQ_ADDR[OFFSET +: INDEX_W];
      req_wsel_q  <= REQ_ADDR[BYTE_W +: WSEL_W];
    end
    if (state_q == LOOKUP) begin
      victim_q       <= victim_way;
      victim_valid_q <= valid_q[req_index_q][victim_way];
    end
    if (((state_q == LOOKUP) && hit) || ((state_q == REFILL) && L2_RDATA_VALID)) resp_q <= merged_word;
  end

  // Valid/dirty bits, round-robin pointers and the flush walk counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      flush_set_q  <= '0;
      flush_way_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= flush_step && flush_last;
      if ((state_q == IDLE) && FLUSH) begin
        flush_set_q <= '0;
        flush_way_q <= '0;
      end
      if (flush_step) begin
        valid_q[flush_set_q][flush_way_q] <= 1'b0;
        dirty_q[flush_set_q][flush_way_q] <= 1'b0;
        if (flush_way_q == WAY_W'(WAYS - 1)) begin
          flush_way_q <= '0;
          flush_set_q <= flush_set_q + 1'b1;
        end else begin
          flush_way_q <= flush_way_q + 1'b1;
        end
      end
      if ((state_q == LOOKUP) && hit && req_write_q) dirty_q[req_index_q][hit_way] <= 1'b1;
      if ((state_q == REFILL) && L2_RDATA_VALID) begin
        valid_q[req_index_q][victim_q] <= 1'b1;
        dirty_q[req_index_q][victim_q] <= req_write_q;
        if (victim_valid_q) begin
          rr_q[req_index_q] <= (rr_q[req_index_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_index_q] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc at default parameters (32-bit words, 8-word lines,
// 128 sets, 2 ways). The L2 model returns a fixed pattern per line address unless the
// line has been written back, in which case it returns the written-back data.
module tb_dcache_assoc;
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         REQ_VALID, REQ_READY, REQ_WRITE;
  logic [31:0]  REQ_ADDR;
  logic [3:0]   REQ_WSTRB;
  logic [31:0]  REQ_WDATA;
  logic         RESP_VALID;
  logic [31:0]  RESP_DATA;
  logic         L2_RADDR_VALID;
  logic [26:0]  L2_RADDR;
  logic [255:0] L2_RDATA;
  logic         L2_RDATA_VALID;
  logic         L2_WVALID;
  logic [26:0]  L2_WADDR;
  logic [255:0] L2_WDATA;
  logic         L2_WDONE;
  logic         FLUSH, FLUSH_DONE;

  dcache_assoc dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WSTRB(REQ_WSTRB), .REQ_WDATA(REQ_WDATA),
    .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA),
    .L2_RADDR_VALID(L2_RADDR_VALID), .L2_RADDR(L2_RADDR),
    .L2_RDATA(L2_RDATA), .L2_RDATA_VALID(L2_RDATA_VALID),
    .L2_WVALID(L2_WVALID), .L2_WADDR(L2_WADDR), .L2_WDATA(L2_WDATA), .L2_WDONE(L2_WDONE),
    .FLUSH(FLUSH), .FLUSH_DONE(FLUSH_DONE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          acc;
  } exp_t;
  exp_t sb[$];

  logic [255:0] l2_mem [int];
  logic [26:0]  wb_addr_q[$];
  logic [255:0] wb_data_q[$];
  int           rd_count = 0;
  logic [26:0]  rd_addr_last = '0;
  bit           l2_mute = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] l2_pattern(input logic [26:0] la);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i * 32 +: 32] = 32'hA000_0000 | (32'(la) << 8) | 32'(i);
    return r;
  endfunction

  // L2 write-back responder: logs the line, updates the L2 image, acks with one WDONE pulse
  initial begin
    L2_WDONE = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (L2_WVALID && !L2_WDONE) begin
        wb_addr_q.push_back(L2_WADDR);
        wb_data_q.push_back(L2_WDATA);
        l2_mem[int'(L2_WADDR)] = L2_WDATA;
        L2_WDONE = 1'b1;
      end else begin
        L2_WDONE = 1'b0;
      end
    end
  end

  // L2 refill responder: one-cycle data pulse per request, can be muted
  initial begin
    L2_RDATA_VALID = 1'b0;
    L2_RDATA = '0;
    forever begin
      @(posedge CLK); #1;
      if (L2_RDATA_VALID) begin
        L2_RDATA_VALID = 1'b0;
      end else if (L2_RADDR_VALID && !l2_mute) begin
        rd_count++;
        rd_addr_last = L2_RADDR;
        L2_RDATA = l2_mem.exists(int'(L2_RADDR)) ? l2_mem[int'(L2_RADDR)] : l2_pattern(L2_RADDR);
        L2_RDATA_VALID = 1'b1;
      end
    end
  end

  // Response monitor: pops the scoreboard on every RESP_VALID
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESP_VALID) begin
        check("resp_single_pulse", 64'(prev_valid), 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'(RESP_DATA), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("resp_data", 64'(RESP_DATA), 64'(e.data));
          // A hit responds in the cycle ending on the second edge after the accept edge,
          // which is the negedge where cyc == acc + 1.
          if (e.hit) check("hit_latency", 64'(cyc - e.acc), 64'd1);
        end
      end
      prev_valid = RESP_VALID;
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, input bit expect_resp,
                       input logic [31:0] exp_data, input bit hit);
    int n;
    exp_t e;
    n = 0;
    @(negedge CLK);
    REQ_VALID = 1'b1;
    REQ_WRITE = wr;
    REQ_ADDR  = addr;
    REQ_WSTRB = strb;
    REQ_WDATA = wdata;
    while (!REQ_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!REQ_READY) begin
      check("accept_timeout", 64'(REQ_READY), 64'd1);
      REQ_VALID = 1'b0;
      return;
    end
    e.data = exp_data;
    e.hit  = hit;
    e.acc  = cyc + 1;
    if (expect_resp) sb.push_back(e);
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("resp_arrived", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, visits, early;
    exp_t e;
    REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_WSTRB = '0; REQ_WDATA = '0;
    FLUSH = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_req_ready", 64'(REQ_READY), 64'd0);
    check("rst_resp_valid", 64'(RESP_VALID), 64'd0);
    check("rst_l2_rvalid", 64'(L2_RADDR_VALID), 64'd0);
    check("rst_l2_wvalid", 64'(L2_WVALID), 64'd0);
    check("rst_flush_done", 64'(FLUSH_DONE), 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("ready_after_rst", 64'(REQ_READY), 64'd1);

    // Cold read, then hit with no L2 traffic
    issue(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 32'hA000_0800, 1'b0); drain();
    check("cold_rd_count", 64'(rd_count), 64'd1);
    check("cold_raddr", 64'(rd_addr_last), 64'h8);
    issue(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 32'hA000_0800, 1'b1); drain();
    check("hit_no_l2", 64'(rd_count), 64'd1);

    // Partial write hit, then read back merged word
    issue(1'b1, 32'h104, 4'b0011, 32'hDEAD_BEEF, 1'b1, 32'hA000_BEEF, 1'b1); drain();
    issue(1'b0, 32'h104, 4'h0, 32'h0, 1'b1, 32'hA000_BEEF, 1'b1); drain();
    check("wr_hit_no_l2", 64'(rd_count), 64'd1);

    // Second way of set 8 fills clean
    issue(1'b0, 32'h1100, 4'h0, 32'h0, 1'b1, 32'hA000_8800, 1'b0); drain();
    check("way1_rd_count", 64'(rd_count), 64'd2);
    check("way1_raddr", 64'(rd_addr_last), 64'h88);
    check("way1_no_wb", 64'(wb_addr_q.size()), 64'd0);

    // Third tag in set 8 evicts the dirty line in way 0
    issue(1'b0, 32'h2100, 4'h0, 32'h0, 1'b1, 32'hA001_0800, 1'b0); drain();
    check("evict_wb_count", 64'(wb_addr_q.size()), 64'd1);
    if (wb_addr_q.size() >= 1) begin
      check("evict_waddr", 64'(wb_addr_q[0]), 64'h8);
      check("evict_wdata_w1", 64'(wb_data_q[0][63:32]), 64'hA000_BEEF);
      check("evict_wdata_w0", 64'(wb_data_q[0][31:0]), 64'hA000_0800);
    end
    check("evict_raddr", 64'(rd_addr_last), 64'h108);
    check("evict_rd_count", 64'(rd_count), 64'd3);

    // Round-robin now picks way 1 (clean); data comes back from the written-back L2 image
    issue(1'b0, 32'h104, 4'h0, 32'h0, 1'b1, 32'hA000_BEEF, 1'b0); drain();
    check("rr_rd_count", 64'(rd_count), 64'd4);
    check("rr_no_wb", 64'(wb_addr_q.size()), 64'd1);

    // Make both lines of set 8 dirty
    issue(1'b1, 32'h2108, 4'b1111, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1); drain();
    issue(1'b1, 32'h100, 4'b1100, 32'hCAFE_0000, 1'b1, 32'hCAFE_0800, 1'b1); drain();

    // Flush raised together with a request: flush wins, request waits for FLUSH_DONE
    @(negedge CLK);
    FLUSH = 1'b1;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 32'h100; REQ_WSTRB = '0;
    @(negedge CLK);
    FLUSH = 1'b0;
    n = 0; visits = 0; early = 0;
    while (!FLUSH_DONE && n < 5000) begin
      if (REQ_READY) early++;
      if (!L2_WVALID || L2_WDONE) visits++;
      @(negedge CLK);
      n++;
    end
    check("flush_done_seen", 64'(FLUSH_DONE), 64'd1);
    check("flush_visits", 64'(visits), 64'd256);
    check("flush_no_early_accept", 64'(early), 64'd0);
    check("ready_after_flush", 64'(REQ_READY), 64'd1);
    e.data = 32'hCAFE_0800; e.hit = 1'b0; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("flush_done_pulse", 64'(FLUSH_DONE), 64'd0);
    check("flush_wb_count", 64'(wb_addr_q.size()), 64'd3);
    if (wb_addr_q.size() >= 3) begin
      check("flush_wb1_addr", 64'(wb_addr_q[1]), 64'h108);
      check("flush_wb1_w2", 64'(wb_data_q[1][95:64]), 64'h1234_5678);
      check("flush_wb2_addr", 64'(wb_addr_q[2]), 64'h8);
      check("flush_wb2_w0", 64'(wb_data_q[2][31:0]), 64'hCAFE_0800);
    end
    drain();
    check("post_flush_miss1", 64'(rd_count), 64'd5);
    issue(1'b0, 32'h2108, 4'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0); drain();
    check("post_flush_miss2", 64'(rd_count), 64'd6);
    issue(1'b0, 32'h1100, 4'h0, 32'h0, 1'b1, 32'hA000_8800, 1'b0); drain();
    check("post_flush_miss3", 64'(rd_count), 64'd7);

    // Reset while waiting in REFILL abandons the fill
    l2_mute = 1'b1;
    issue(1'b0, 32'h3100, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    n = 0;
    while (!L2_RADDR_VALID && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("refill_seen", 64'(L2_RADDR_VALID), 64'd1);
    check("refill_raddr", 64'(L2_RADDR), 64'h188);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_drops_rvalid", 64'(L2_RADDR_VALID), 64'd0);
    RST = 1'b0;
    l2_mute = 1'b0;
    @(negedge CLK);
    check("ready_after_rst2", 64'(REQ_READY), 64'd1);
    issue(1'b0, 32'h3100, 4'h0, 32'h0, 1'b1, 32'hA001_8800, 1'b0); drain();
    check("rst_refill_misses", 64'(rd_count), 64'd8);
    issue(1'b0, 32'h2108, 4'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0); drain();
    check("rst_clears_valid", 64'(rd_count), 64'd9);

    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
